// File: rtl/mem_bus_pkg.sv
// Shared types and address-map constants for the data/peripheral bus arbiter
// and any other block that needs the same region decode (e.g. the MEM stage).
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    REG_DM = 2'd0,
    REG_TM = 2'd1,
    REG_UM = 2'd2
  } region_t;

  localparam int unsigned PER_BASE_BIT = 30;
  localparam logic [7:0]  TM_LIMIT     = 8'h15;

  function automatic region_t decode_region(input logic [31:0] addr);
    region_t r;
    if (!addr[PER_BASE_BIT])
      r = REG_DM;
    else if (addr[7:0] < TM_LIMIT)
      r = REG_TM;
    else
      r = REG_UM;
    return r;
  endfunction

  // Strobe vector order: {dm_rd, dm_wr, tm_rd, tm_wr, um_rd, um_wr}
  function automatic logic [5:0] strobe_sel(input region_t region, input logic wr);
    logic [5:0] s;
    s = '0;
    unique case (region)
      REG_DM:  s = wr ? 6'b01_00_00 : 6'b10_00_00;
      REG_TM:  s = wr ? 6'b00_01_00 : 6'b00_10_00;
      default: s = wr ? 6'b00_00_01 : 6'b00_00_10;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mem_bus_decoder.sv
// Combinational byte-address to bus-region decode (DM / timer / UART).
module mem_bus_decoder
  import mem_bus_pkg::*;
(
  input  logic [31:0] addr,
  output logic [1:0]  region
);

  assign region = decode_region(addr);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master (MEM stage C, UART DMA D) arbiter for the data/peripheral bus.
// Optional macro ARB_ROUND_ROBIN_EN: strict C/D alternation instead of
// C-priority with MAX_SKIP anti-starvation.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned DM_WAIT  = 0,
  parameter int unsigned PER_WAIT = 2,
  parameter int unsigned MAX_SKIP = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c_req,
  input  logic        c_wr,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_ack,
  output logic [31:0] c_rdata,
  output logic        c_stall,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        dm_rd,
  output logic        dm_wr,
  output logic        tm_rd,
  output logic        tm_wr,
  output logic        um_rd,
  output logic        um_wr,
  input  logic [31:0] dm_data,
  input  logic [31:0] tm_data,
  input  logic [31:0] um_data
);

  state_t      state_q, state_n;
  logic        id_q, id_n;
  logic        wr_q, wr_n;
  region_t     region_q, region_n;
  logic [3:0]  wcnt_q, wcnt_n;
  logic [31:0] addr_n, wdata_n;
  logic [31:0] rdbuf_q, rdbuf_n;
  logic [5:0]  strb_q, strb_n;
  logic        c_ack_n, d_ack_n;

  logic        win_d;
  logic        win_wr;
  logic [31:0] win_addr;
  logic [31:0] win_wdata;
  logic [1:0]  win_region_raw;
  region_t     win_region;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d_q, last_d_n;
  assign win_d = d_req & (~c_req | ~last_d_q);
`else
  logic [3:0] skip_q, skip_n;
  assign win_d = d_req & (~c_req | (skip_q == 4'(MAX_SKIP)));
`endif

  assign win_wr    = win_d ? d_wr    : c_wr;
  assign win_addr  = win_d ? d_addr  : c_addr;
  assign win_wdata = win_d ? d_wdata : c_wdata;

  mem_bus_decoder u_dec (
    .addr   (win_addr),
    .region (win_region_raw)
  );

  assign win_region = region_t'(win_region_raw);

  always_comb begin
    state_n  = state_q;
    id_n     = id_q;
    wr_n     = wr_q;
    region_n = region_q;
    wcnt_n   = wcnt_q;
    addr_n   = bus_addr;
    wdata_n  = bus_wdata;
    rdbuf_n  = rdbuf_q;
    strb_n   = '0;
    c_ack_n  = 1'b0;
    d_ack_n  = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_d_n = last_d_q;
`else
    skip_n   = skip_q;
`endif

    unique case (state_q)
      IDLE: begin
`ifndef ARB_ROUND_ROBIN_EN
        if (!d_req || win_d)
          skip_n = '0;
        else if (skip_q < 4'(MAX_SKIP))
          skip_n = skip_q + 4'd1;
`endif
        if (c_req || d_req) begin
          state_n  = ACC;
          id_n     = win_d;
          wr_n     = win_wr;
          addr_n   = win_addr;
          wdata_n  = win_wdata;
          region_n = win_region;
          wcnt_n   = (win_region == REG_DM) ? 4'(DM_WAIT) : 4'(PER_WAIT);
          strb_n   = strobe_sel(win_region, win_wr);
`ifdef ARB_ROUND_ROBIN_EN
          last_d_n = win_d;
`endif
        end
      end

      ACC: begin
        if (wcnt_q != '0) begin
          wcnt_n = wcnt_q - 4'd1;
          strb_n = strb_q;
        end else begin
          state_n = DONE;
          if (wr_q)
            rdbuf_n = '0;
          else begin
            unique case (region_q)
              REG_DM:  rdbuf_n = dm_data;
              REG_TM:  rdbuf_n = tm_data;
              default: rdbuf_n = um_data;
            endcase
          end
          // Acks are registered so they land in the DONE cycle.
          c_ack_n = ~id_q;
          d_ack_n = id_q;
        end
      end

      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      id_q      <= 1'b0;
      wr_q      <= 1'b0;
      region_q  <= REG_DM;
      wcnt_q    <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      rdbuf_q   <= '0;
      strb_q    <= '0;
      c_ack     <= 1'b0;
      d_ack     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_q  <= 1'b1;
`else
      skip_q    <= '0;
`endif
    end else begin
      state_q   <= state_n;
      id_q      <= id_n;
      wr_q      <= wr_n;
      region_q  <= region_n;
      wcnt_q    <= wcnt_n;
      bus_addr  <= addr_n;
      bus_wdata <= wdata_n;
      rdbuf_q   <= rdbuf_n;
      strb_q    <= strb_n;
      c_ack     <= c_ack_n;
      d_ack     <= d_ack_n;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_q  <= last_d_n;
`else
      skip_q    <= skip_n;
`endif
    end
  end

  assign {dm_rd, dm_wr, tm_rd, tm_wr, um_rd, um_wr} = strb_q;

  assign c_rdata = rdbuf_q;
  assign d_rdata = rdbuf_q;
  assign c_stall = c_req & ~c_ack;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed plus randomized rounds
// against a transaction-schedule reference model.
module tb_mem_bus_arbiter;

  localparam int unsigned DM_W  = 0;
  localparam int unsigned PER_W = 2;
  localparam int unsigned MSKIP = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        c_req, c_wr, d_req, d_wr;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic        c_ack, d_ack, c_stall;
  logic [31:0] c_rdata, d_rdata, bus_addr, bus_wdata;
  logic        dm_rd, dm_wr, tm_rd, tm_wr, um_rd, um_wr;
  logic [31:0] dm_data, tm_data, um_data;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  int unsigned m_skip   = 0;
  bit          m_last_d = 1'b1;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .DM_WAIT  (DM_W),
    .PER_WAIT (PER_W),
    .MAX_SKIP (MSKIP)
  ) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_wr(c_wr), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ack(c_ack), .c_rdata(c_rdata), .c_stall(c_stall),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .tm_rd(tm_rd), .tm_wr(tm_wr),
    .um_rd(um_rd), .um_wr(um_wr),
    .dm_data(dm_data), .tm_data(tm_data), .um_data(um_data)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] strobes_now();
    return {dm_rd, dm_wr, tm_rd, tm_wr, um_rd, um_wr};
  endfunction

  // 0 = data memory, 1 = timer, 2 = UART
  function automatic int unsigned region_of(input logic [31:0] a);
    if (a[30] == 1'b0)      return 0;
    if (a[7:0] < 8'h15)     return 1;
    return 2;
  endfunction

  function automatic int unsigned wait_of(input int unsigned r);
    return (r == 0) ? DM_W : PER_W;
  endfunction

  function automatic logic [5:0] exp_strobe(input int unsigned r, input bit wr);
    logic [5:0] top;
    top = 6'b100000;
    return top >> (r * 2 + (wr ? 1 : 0));
  endfunction

  function automatic logic [31:0] slave_val(input int unsigned r);
    return (r == 0) ? dm_data : (r == 1) ? tm_data : um_data;
  endfunction

  function automatic bit model_pick_d(input bit c, input bit d);
`ifdef ARB_ROUND_ROBIN_EN
    return d && (!c || !m_last_d);
`else
    return d && (!c || m_skip == MSKIP);
`endif
  endfunction

  task automatic model_grant(input bit d, input bit won_d);
`ifdef ARB_ROUND_ROBIN_EN
    m_last_d = won_d;
`else
    if (!d || won_d) m_skip = 0;
    else if (m_skip < MSKIP) m_skip++;
`endif
  endtask

  task automatic model_reset();
    m_skip   = 0;
    m_last_d = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    c_req = 1'b0; d_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
  endtask

  // One round: requests raised together in cycle 0, expected per-cycle
  // strobes/acks derived from the grant order and wait-state rule.
  task automatic run_round(input bit c_on, input bit d_on, input bit cw, input bit dw,
                           input logic [31:0] ca, input logic [31:0] da,
                           input logic [31:0] cwd, input logic [31:0] dwd,
                           input bit c_drop);
    logic [5:0]  e_strb[64];
    bit          e_ca[64], e_da[64], e_wr[64];
    logic [31:0] e_addr[64], e_wd[64], e_rd[64];
    bit          order[2];
    int unsigned n, t, total;
    bit          drop;

    for (int i = 0; i < 64; i++) begin
      e_strb[i] = '0; e_ca[i] = 0; e_da[i] = 0; e_wr[i] = 0;
      e_addr[i] = '0; e_wd[i] = '0; e_rd[i] = '0;
    end

    if (c_on && d_on) begin
      order[0] = model_pick_d(1'b1, 1'b1);
      order[1] = !order[0];
      model_grant(1'b1, order[0]);
      model_grant(order[1], order[1]);
      n = 2;
    end else begin
      order[0] = d_on;
      order[1] = 1'b0;
      model_grant(d_on, d_on);
      n = 1;
    end
    drop = c_drop && c_on && (order[0] == 1'b0);

    t = 1;
    total = 0;
    for (int unsigned i = 0; i < n; i++) begin
      logic [31:0] a, w;
      bit          wr;
      int unsigned r, wt;
      a  = order[i] ? da : ca;
      w  = order[i] ? dwd : cwd;
      wr = order[i] ? dw : cw;
      r  = region_of(a);
      wt = wait_of(r);
      for (int unsigned k = t; k <= t + wt; k++) begin
        e_strb[k] = exp_strobe(r, wr);
        e_addr[k] = a;
        e_wd[k]   = w;
        e_wr[k]   = wr;
      end
      if (order[i]) e_da[t + wt + 1] = 1;
      else          e_ca[t + wt + 1] = 1;
      e_rd[t + wt + 1] = wr ? 32'h0 : slave_val(r);
      total = t + wt + 2;
      t = t + wt + 3;
    end

    c_req = c_on; c_wr = cw; c_addr = ca; c_wdata = cwd;
    d_req = d_on; d_wr = dw; d_addr = da; d_wdata = dwd;

    for (int unsigned cyc = 0; cyc < total; cyc++) begin
      @(negedge clk);
      check_eq($sformatf("strobes c%0d", cyc), 32'(strobes_now()), 32'(e_strb[cyc]));
      check_eq($sformatf("c_ack c%0d", cyc), 32'(c_ack), 32'(e_ca[cyc]));
      check_eq($sformatf("d_ack c%0d", cyc), 32'(d_ack), 32'(e_da[cyc]));
      check_eq($sformatf("c_stall c%0d", cyc), 32'(c_stall), 32'(c_req & !e_ca[cyc]));
      if (e_strb[cyc] != '0) begin
        check_eq($sformatf("bus_addr c%0d", cyc), bus_addr, e_addr[cyc]);
        if (e_wr[cyc]) check_eq($sformatf("bus_wdata c%0d", cyc), bus_wdata, e_wd[cyc]);
      end
      if (e_ca[cyc]) begin
        check_eq("c_rdata", c_rdata, e_rd[cyc]);
        c_req = 1'b0;
      end
      if (e_da[cyc]) begin
        check_eq("d_rdata", d_rdata, e_rd[cyc]);
        d_req = 1'b0;
      end
      if (drop && cyc == 1) c_req = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 3))
      0:       return $urandom & 32'hBFFF_FFFF;
      1:       return ($urandom & 32'hBFFF_FF00) | 32'h4000_0000 | 32'($urandom_range(0, 20));
      2:       return $urandom | 32'h4000_0000;
      default: return ($urandom_range(0, 1) != 0) ? 32'h4000_0014 : 32'h4000_0015;
    endcase
  endfunction

  initial begin
    int unsigned grants;
    c_req = 0; c_wr = 0; c_addr = '0; c_wdata = '0;
    d_req = 0; d_wr = 0; d_addr = '0; d_wdata = '0;
    dm_data = 32'h1111_1111; tm_data = 32'h2222_2222; um_data = 32'h3333_3333;
    reset = 1'b0;
    do_reset();

    @(negedge clk);
    check_eq("rst strobes", 32'(strobes_now()), 32'h0);
    check_eq("rst acks", 32'({c_ack, d_ack}), 32'h0);
    check_eq("rst bus_addr", bus_addr, 32'h0);
    check_eq("rst bus_wdata", bus_wdata, 32'h0);
    check_eq("rst c_rdata", c_rdata, 32'h0);
    check_eq("rst d_rdata", d_rdata, 32'h0);
    @(posedge clk); #1;

    // C withdraws mid-access; D queued behind it
    run_round(1, 1, 0, 0, 32'h0000_0040, 32'h4000_0030, '0, '0, 1);

    dm_data = 32'hDEAD_BEEF;
    run_round(1, 0, 0, 0, 32'h0000_0010, '0, '0, '0, 0);
    run_round(0, 1, 0, 1, '0, 32'h4000_0018, '0, 32'h1234_5678, 0);
    tm_data = 32'hCAFE_0014; um_data = 32'hBEEF_0015;
    run_round(1, 0, 0, 0, 32'h4000_0014, '0, '0, '0, 0);
    run_round(1, 0, 0, 0, 32'h4000_0015, '0, '0, '0, 0);

    // Reset during the second ACC cycle of a UART read
    c_req = 1; c_wr = 0; c_addr = 32'h4000_0020;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("pre-rst um_rd", 32'(strobes_now()), 32'(exp_strobe(2, 0)));
    @(posedge clk); #1;
    reset = 1'b0; c_req = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("midrst strobes", 32'(strobes_now()), 32'h0);
    check_eq("midrst acks", 32'({c_ack, d_ack}), 32'h0);
    check_eq("midrst bus_addr", bus_addr, 32'h0);
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq($sformatf("post-rst no ack %0d", i), 32'({c_ack, d_ack}), 32'h0);
    end
    @(posedge clk); #1;
    run_round(1, 0, 0, 0, 32'h0000_0080, '0, '0, '0, 0);

    // Both masters requesting continuously
    do_reset();
    c_req = 1; c_wr = 0; c_addr = 32'h0000_0100;
    d_req = 1; d_wr = 0; d_addr = 32'h0000_0200;
    grants = 0;
    for (int cyc = 0; cyc < 400 && grants < 10; cyc++) begin
      @(negedge clk);
      if (c_ack || d_ack) begin
        bit exp_d;
        exp_d = model_pick_d(1'b1, 1'b1);
        model_grant(1'b1, exp_d);
        check_eq($sformatf("arb grant %0d", grants), 32'({c_ack, d_ack}),
                 exp_d ? 32'h1 : 32'h2);
        grants++;
        if (grants == 10) begin c_req = 0; d_req = 0; end
      end
    end
    check_eq("arb grants seen", grants, 10);
    c_req = 0; d_req = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    m_skip = 0;

    for (int i = 0; i < 40; i++) begin
      int unsigned v;
      v = $urandom_range(1, 3);
      dm_data = $urandom; tm_data = $urandom; um_data = $urandom;
      run_round(v[0], v[1], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                pick_addr(), pick_addr(), $urandom, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single data/peripheral bus (data memory, timer block, UART block) between two masters: pipeline MEM stage (port C) and UART DMA engine (port D).
- Arbitrates, decodes the target region, drives registered strobes for a programmable number of wait states, returns read data with a one-cycle ack.
- Drives a stall to the pipeline while the MEM-stage access is outstanding.
- Sits between the MEM stage and the DataMem/timer/UART slaves.

Parameters:
- DM_WAIT, 0, extra strobe cycles for data-memory accesses (0..15).
- PER_WAIT, 2, extra strobe cycles for timer/UART accesses (0..15).
- MAX_SKIP, 4, consecutive lost arbitrations after which port D is forced to win (1..15).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- c_req  in  1  MEM-stage request; held with c_wr/c_addr/c_wdata until c_ack
- c_wr  in  1  1=write, 0=read
- c_addr  in  32  byte address
- c_wdata  in  32  write data
- c_ack  out  1  one-cycle completion pulse
- c_rdata  out  32  read data, valid while c_ack=1
- c_stall  out  1  c_req & ~c_ack (combinational)
- d_req, d_wr, d_addr, d_wdata, d_ack, d_rdata  same as port C, for the DMA engine
- bus_addr  out  32  registered address to slaves
- bus_wdata  out  32  registered write data
- dm_rd, dm_wr, tm_rd, tm_wr, um_rd, um_wr  out  1 each  registered slave strobes
- dm_data, tm_data, um_data  in  32  slave read data

Behaviour:
- Region decode, applied to the winner's address:
  - addr[30]=0 → DM.
  - addr[30]=1 and addr[7:0] < 8'h15 → TM.
  - otherwise → UM.
- FSM states: IDLE, ACC, DONE.
- IDLE:
  - No request → stay.
  - Any request → pick a winner; latch its id, wr, addr, wdata, region; load wcnt = DM_WAIT or PER_WAIT; go to ACC.
- ACC:
  - Exactly one strobe high: region's rd or wr per the latched wr.
  - bus_addr/bus_wdata hold the latched values.
  - wcnt>0 → decrement, stay.
  - wcnt==0 → capture the region's data into rdbuf when it is a read (0 for writes), go to DONE.
  - Strobes are therefore high for W+1 cycles.
- DONE:
  - Winner's ack=1 and rdata=rdbuf for exactly one cycle; all strobes 0; go to IDLE.
- Latency: req seen at edge 0 → strobes cycles 1..1+W → ack in cycle 2+W. Minimum repeat interval is 3+W cycles, because DONE returns to IDLE.
- Arbitration:
  - Port C wins by default.
  - skip counter increments whenever D requests and loses; it saturates at MAX_SKIP.
  - When skip==MAX_SKIP and D requests, D wins.
  - skip clears when D wins or when D is not requesting in IDLE.
- Request handling:
  - A request dropped during ACC/DONE does not abort; the access completes and the ack is still issued.
  - The requester ignores a stale ack.
  - Requests are sampled only in IDLE.
- Both requesting, same address: serialized; no merging.
- rdata outputs hold the last rdbuf value outside ack; they are only defined under ack.
- Reset (reset=0 at a rising edge):
  - State, latched fields, and wcnt/skip clear; state→IDLE.
  - All strobes, acks, bus_addr, bus_wdata, c_rdata, d_rdata → 0.
  - Takes effect even mid-ACC; the interrupted access is lost, no ack.

Optional Feature:
- ARB_ROUND_ROBIN_EN defined: replaces C-priority/skip logic with strict alternation.
  - When both request, the port that did not win last wins.
  - last-winner flag resets to D, so C wins first.
  - skip counter and MAX_SKIP unused.
- Undefined: C-priority with MAX_SKIP anti-starvation, as above.

Decomposition:
- Shared package mem_bus_pkg:
  - state encoding (IDLE/ACC/DONE), region encoding (REG_DM/REG_TM/REG_UM).
  - constants PER_BASE_BIT=30, TM_LIMIT=8'h15.
  - function decode_region(addr).
- One natural sub-module: mem_bus_decoder (combinational address→region). The same decode is reused by the MEM stage.
- FSM, counters, and arbitration stay in the top level.

Test Plan:
- C read DM, DM_WAIT=0, c_addr=0x0000_0010, dm_data=0xDEAD_BEEF:
  - dm_rd=1 in cycle 1 only.
  - c_ack=1, c_rdata=0xDEAD_BEEF in cycle 2.
  - c_stall=1 in cycles 0–1.
- D write UART, d_addr=0x4000_0018, PER_WAIT=2:
  - um_wr=1 in cycles 1–3, bus_wdata=d_wdata.
  - d_ack in cycle 4; tm/dm strobes stay 0.
- Timer boundary:
  - addr 0x4000_0014 → tm_rd.
  - addr 0x4000_0015 → um_rd.
- Starvation, MAX_SKIP=4, C and D requesting continuously:
  - C wins 4 consecutive grants, D wins the 5th, then C resumes.
  - With ARB_ROUND_ROBIN_EN: C, D, C, D alternation.
- Reset mid-access:
  - reset=0 during the 2nd ACC cycle of a UART read.
  - Next edge: all strobes 0, no ack, state IDLE.
  - After release, a fresh C request completes normally.
- Requester withdraws: c_req dropped during ACC → access completes, c_ack still pulses once; D queued behind it is granted next.
